uart_tx_ctrl: RTL and testbench

Frame controller for the UART transmitter. It accepts a byte handshake and sequences the 8-bit serializer through the frame: start bit, data bits LSB-first, optional parity bit, then stop bit(s). It computes parity and drives the TX line mux. It sits between the upstream byte source and the TX pin, alongside the serializer (load on Data_Valid && !busy, shift and count on ser_en, ser_done combinational at count 7).

---
 rtl/uart_tx_ctrl.sv | 101 ++++++++++
 tb/tb_uart_tx_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: sequences start, data (via external serializer),
// optional parity and stop bit(s), and drives the TX line from the state register.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Data_Valid,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic                  busy,
    output logic                  TX_OUT,
    output logic                  frame_done
);

    localparam int SCW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
    localparam logic [SCW-1:0] STOP_LAST = SCW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e         state_q, state_d;
    logic           par_bit_q, par_bit_d;
    logic           par_en_q, par_en_d;
    logic [SCW-1:0] stop_cnt_q, stop_cnt_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            par_bit_q  <= 1'b0;
            par_en_q   <= 1'b0;
            stop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            par_bit_q  <= par_bit_d;
            par_en_q   <= par_en_d;
            stop_cnt_q <= stop_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        par_bit_d  = par_bit_q;
        par_en_d   = par_en_q;
        stop_cnt_d = stop_cnt_q;
        TX_OUT     = 1'b1;
        busy       = 1'b0;
        ser_en     = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            IDLE: begin
                // Frame config is captured only here, so mid-frame changes never leak in.
                if (Data_Valid) begin
                    state_d    = START;
                    par_bit_d  = (^P_DATA) ^ PAR_TYP;
                    par_en_d   = PAR_EN;
                    stop_cnt_d = '0;
                end
            end
            START: begin
                TX_OUT  = 1'b0;
                busy    = 1'b1;
                state_d = DATA;
            end
            DATA: begin
                TX_OUT = ser_data;
                busy   = 1'b1;
                ser_en = 1'b1;
                if (ser_done) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                TX_OUT  = par_bit_q;
                busy    = 1'b1;
                state_d = STOP;
            end
            STOP: begin
                busy       = 1'b1;
                stop_cnt_d = stop_cnt_q + SCW'(1);
                if (stop_cnt_q == STOP_LAST) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: two instances (1 and 2 stop bits), each with a
// small behavioural serializer, checked cycle by cycle against hand-computed frames.
module tb_uart_tx_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Data_Valid = 1'b0;
    logic       dv2 = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       sd_inj = 1'b0;

    logic ser_en1, busy1, tx1, fd1, ser_done1, ser_data1;
    logic ser_en2, busy2, tx2, fd2, ser_done2, ser_data2;
    logic [7:0] sh1, sh2;
    logic [2:0] cnt1, cnt2;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) u_dut (
        .CLK(CLK), .RST(RST), .Data_Valid(Data_Valid), .P_DATA(P_DATA),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ser_done(ser_done1), .ser_data(ser_data1),
        .ser_en(ser_en1), .busy(busy1), .TX_OUT(tx1), .frame_done(fd1)
    );

    uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2)) u_dut2 (
        .CLK(CLK), .RST(RST), .Data_Valid(dv2), .P_DATA(P_DATA),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ser_done(ser_done2), .ser_data(ser_data2),
        .ser_en(ser_en2), .busy(busy2), .TX_OUT(tx2), .frame_done(fd2)
    );

    // Serializer models: load on request when idle, shift on ser_en, done at count 7.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sh1 <= 8'h00; cnt1 <= 3'd0;
        end else if (Data_Valid && !busy1) begin
            sh1 <= P_DATA; cnt1 <= 3'd0;
        end else if (ser_en1) begin
            sh1 <= sh1 >> 1; cnt1 <= cnt1 + 3'd1;
        end
    end
    assign ser_data1 = sh1[0];
    assign ser_done1 = (cnt1 == 3'd7) | sd_inj;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sh2 <= 8'h00; cnt2 <= 3'd0;
        end else if (dv2 && !busy2) begin
            sh2 <= P_DATA; cnt2 <= 3'd0;
        end else if (ser_en2) begin
            sh2 <= sh2 >> 1; cnt2 <= cnt2 + 3'd1;
        end
    end
    assign ser_data2 = sh2[0];
    assign ser_done2 = (cnt2 == 3'd7);

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got tx/busy/ser_en/fd=%b exp %b", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic tx, input logic b, input logic se, input logic fd);
        cmp(tag, {tx1, busy1, ser_en1, fd1}, {tx, b, se, fd});
    endtask

    task automatic chk2(input string tag, input logic tx, input logic b, input logic se, input logic fd);
        cmp(tag, {tx2, busy2, ser_en2, fd2}, {tx, b, se, fd});
    endtask

    // Called just after the acceptance edge; ends in the stop cycle.
    task automatic frame_body(input string tag, input logic [7:0] d, input logic pe, input logic pbit);
        chk1({tag, "_start"}, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk1($sformatf("%s_d%0d", tag, i), d[i], 1'b1, 1'b1, 1'b0);
        end
        if (pe) begin
            tick();
            chk1({tag, "_par"}, pbit, 1'b1, 1'b0, 1'b0);
        end
        tick();
        chk1({tag, "_stop"}, 1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held 3 cycles, then idle with stray ser_done pulses.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("rst_hold", 1'b1, 1'b0, 1'b0, 1'b0);
        end
        RST = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sd_inj = (i % 3 == 0);
            tick();
            chk1("idle", 1'b1, 1'b0, 1'b0, 1'b0);
            chk2("idle2", 1'b1, 1'b0, 1'b0, 1'b0);
        end
        sd_inj = 1'b0;

        // 0xA5 even parity; config changed mid-frame must not affect it.
        P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0; PAR_TYP = 1'b1; P_DATA = 8'h00;
        frame_body("a5", 8'hA5, 1'b1, 1'b0);
        tick();
        chk1("a5_idle", 1'b1, 1'b0, 1'b0, 1'b0);

        // 0x01 odd -> parity 0; ser_done stuck high outside DATA has no effect.
        P_DATA = 8'h01; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0; sd_inj = 1'b1;
        chk1("o1_start", 1'b0, 1'b1, 1'b0, 1'b0);
        sd_inj = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk1($sformatf("o1_d%0d", i), (i == 0), 1'b1, 1'b1, 1'b0);
        end
        tick();
        chk1("o1_par", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk1("o1_stop", 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        chk1("o1_idle", 1'b1, 1'b0, 1'b0, 1'b0);

        // 0x03 odd -> parity 1.
        P_DATA = 8'h03; Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        frame_body("o3", 8'h03, 1'b1, 1'b1);
        tick();
        chk1("o3_idle", 1'b1, 1'b0, 1'b0, 1'b0);

        // 0xFF no parity, Data_Valid held: mid-frame request ignored, one idle gap.
        P_DATA = 8'hFF; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        tick();
        P_DATA = 8'h0F; PAR_EN = 1'b1; PAR_TYP = 1'b1;
        frame_body("ff", 8'hFF, 1'b0, 1'b0);
        tick();
        chk1("ff_gap", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        Data_Valid = 1'b0;
        frame_body("0f", 8'h0F, 1'b1, 1'b1);
        tick();
        chk1("0f_idle", 1'b1, 1'b0, 1'b0, 1'b0);

        // Two stop bits: frame_done only on the second.
        P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0; dv2 = 1'b1;
        tick();
        dv2 = 1'b0;
        chk2("s2_start", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk2($sformatf("s2_d%0d", i), 1'b0, 1'b1, 1'b1, 1'b0);
        end
        tick();
        chk2("s2_stop1", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk2("s2_stop2", 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        chk2("s2_idle", 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset during data bit 4 of 0xA5, then a clean 0x3C frame.
        P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        chk1("rm_start", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1($sformatf("rm_d%0d", i), P_DATA[i], 1'b1, 1'b1, 1'b0);
        end
        #1 RST = 1'b0;
        #1 chk1("rm_async", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        RST = 1'b1;
        tick();
        chk1("rm_after", 1'b1, 1'b0, 1'b0, 1'b0);
        P_DATA = 8'h3C; Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        frame_body("3c", 8'h3C, 1'b1, 1'b0);
        tick();
        chk1("3c_idle", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
